// File: rtl/mult_pkg.sv
// Shared defaults and state encoding for the multiplier accumulator stage.
package mult_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / result-out handshake bundle between the LUT multiplier, the
// accumulator stage and the MiniALU result path.
interface mult_accumulator_if
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [PROD_W-1:0] iProduct;
  logic              iValid;
  logic              iLast;
  logic              oReady;
  logic [ACC_W-1:0]  oResult;
  logic [CNT_W-1:0]  oCount;
  logic              oValid;
  logic              iReady;
  logic              oOverflow;

  modport master (
    output iProduct, iValid, iLast, iReady,
    input  oReady, oResult, oCount, oValid, oOverflow
  );

  modport slave (
    input  iProduct, iValid, iLast, iReady,
    output oReady, oResult, oCount, oValid, oOverflow
  );

endinterface

// File: rtl/acc_sat_add.sv
// Accumulator adder with carry-out; MULT_ACC_SAT_EN selects clamp-to-all-ones
// instead of modulo wrap when the sum leaves ACC_W bits.
module acc_sat_add
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  function automatic logic [ACC_W-1:0] limit_sum(input logic [ACC_W:0] w);
`ifdef MULT_ACC_SAT_EN
    return w[ACC_W] ? {ACC_W{1'b1}} : w[ACC_W-1:0];
`else
    return w[ACC_W-1:0];
`endif
  endfunction

  always_comb begin
    wide  = {1'b0, acc} + (ACC_W+1)'(product);
    carry = wide[ACC_W];
    sum   = limit_sum(wide);
  end

endmodule

// File: rtl/mult_accumulator.sv
// Burst accumulator behind the LUT multiplier: sums a burst of unsigned products
// and holds the result until the consumer takes it (MULT_ACC_SAT_EN: saturate).
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  mult_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_p0, state_p1;
  logic [ACC_W-1:0]   acc_p0, acc_p1;
  logic [CNT_W-1:0]   cnt_p0, cnt_p1;
  logic               ovf_p0, ovf_p1;
  logic               vld_p0, vld_p1;
  logic               rdy_p0, rdy_p1;

  logic               accept;
  logic               in_accum;
  logic [ACC_W-1:0]   add_base;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic [CNT_W-1:0]   cnt_inc;
  logic               closes;

  assign accept   = bus.iValid && rdy_p1;
  assign in_accum = (state_p1 == ACCUM);
  // The first beat of a burst starts from zero so the adder also loads it.
  assign add_base = in_accum ? acc_p1 : '0;
  assign cnt_inc  = in_accum ? cnt_p1 + CNT_W'(1) : CNT_W'(1);
  assign closes   = bus.iLast || (cnt_inc == CNT_MAX);

  acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc     (add_base),
    .product (bus.iProduct),
    .sum     (sum),
    .carry   (carry)
  );

  always_comb begin
    state_p0 = state_p1;
    acc_p0   = acc_p1;
    cnt_p0   = cnt_p1;
    ovf_p0   = ovf_p1;
    vld_p0   = vld_p1;
    rdy_p0   = rdy_p1;
    unique case (state_p1)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_p0 = sum;
          cnt_p0 = cnt_inc;
          ovf_p0 = in_accum ? (ovf_p1 | carry) : carry;
          if (closes) begin
            state_p0 = HOLD;
            vld_p0   = 1'b1;
            rdy_p0   = 1'b0;
          end else begin
            state_p0 = ACCUM;
          end
        end
      end
      HOLD: begin
        if (bus.iReady) begin
          state_p0 = IDLE;
          vld_p0   = 1'b0;
          rdy_p0   = 1'b1;
        end
      end
      default: begin
        state_p0 = IDLE;
        vld_p0   = 1'b0;
        rdy_p0   = 1'b1;
      end
    endcase
  end

  // p1: registered state and outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_p1 <= IDLE;
      acc_p1   <= '0;
      cnt_p1   <= '0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      rdy_p1   <= 1'b1;
    end else begin
      state_p1 <= state_p0;
      acc_p1   <= acc_p0;
      cnt_p1   <= cnt_p0;
      ovf_p1   <= ovf_p0;
      vld_p1   <= vld_p0;
      rdy_p1   <= rdy_p0;
    end
  end

  assign bus.oResult   = acc_p1;
  assign bus.oCount    = cnt_p1;
  assign bus.oOverflow = ovf_p1;
  assign bus.oValid    = vld_p1;
  assign bus.oReady    = rdy_p1;

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: default build plus a narrow ACC_W=33/CNT_W=2 instance.
module tb_mult_accumulator;

`ifdef MULT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 Clock = ~Clock;

  mult_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) ifa ();
  mult_accumulator_if #(.PROD_W(32), .ACC_W(33), .CNT_W(2)) ifb ();

  mult_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifa.slave)
  );

  mult_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(2)) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifb.slave)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Sum of a burst from plain arithmetic: wrap or clamp whenever the running
  // total reaches 2^w, with a sticky overflow flag.
  function automatic void model(input logic [63:0] q[$], input int w,
                                output logic [63:0] res, output logic ovf);
    logic [63:0] lim;
    logic [63:0] s;
    lim = 64'd1 << w;
    s   = '0;
    ovf = 1'b0;
    foreach (q[i]) begin
      s = s + q[i];
      if (s >= lim) begin
        ovf = 1'b1;
        s   = SAT ? lim - 64'd1 : s - lim;
      end
    end
    res = s;
  endfunction

  task automatic send_a(input logic [31:0] p, input logic last);
    int n;
    n = 0;
    ifa.iValid = 1'b1; ifa.iProduct = p; ifa.iLast = last;
    while (ifa.oReady !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (n >= 20) begin
      total++; fails++;
      $error("FAIL a_accept_timeout: observed oReady=%0b expected 1", ifa.oReady);
    end
    tick(1);
    ifa.iValid = 1'b0; ifa.iLast = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] p, input logic last);
    int n;
    n = 0;
    ifb.iValid = 1'b1; ifb.iProduct = p; ifb.iLast = last;
    while (ifb.oReady !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (n >= 20) begin
      total++; fails++;
      $error("FAIL b_accept_timeout: observed oReady=%0b expected 1", ifb.oReady);
    end
    tick(1);
    ifb.iValid = 1'b0; ifb.iLast = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_result"}, 64'(ifa.oResult), 64'd0);
    chk({tag, "_count"},  64'(ifa.oCount), 64'd0);
    chk({tag, "_valid"},  64'(ifa.oValid), 64'd0);
    chk({tag, "_ovf"},    64'(ifa.oOverflow), 64'd0);
    chk({tag, "_ready"},  64'(ifa.oReady), 64'd1);
  endtask

  logic [63:0] q[$];
  logic [63:0] er;
  logic        eo;
  logic [31:0] p;
  logic        lst;
  int          len;
  int          hold;

  initial begin
    ifa.iProduct = '0; ifa.iValid = 1'b0; ifa.iLast = 1'b0; ifa.iReady = 1'b0;
    ifb.iProduct = '0; ifb.iValid = 1'b0; ifb.iLast = 1'b0; ifb.iReady = 1'b0;
    Reset = 1'b1;
    tick(2);
    chk_reset_a("reset");
    chk("reset_b_ready", 64'(ifb.oReady), 64'd1);
    Reset = 1'b0;

    // single beat
    ifa.iReady = 1'b1;
    send_a(32'd25, 1'b1);
    chk("single_valid", 64'(ifa.oValid), 64'd1);
    chk("single_result", 64'(ifa.oResult), 64'd25);
    chk("single_count", 64'(ifa.oCount), 64'd1);
    chk("single_ovf", 64'(ifa.oOverflow), 64'd0);
    chk("single_ready_low", 64'(ifa.oReady), 64'd0);
    tick(1);
    chk("single_valid_drop", 64'(ifa.oValid), 64'd0);
    chk("single_ready_back", 64'(ifa.oReady), 64'd1);
    chk("single_result_kept", 64'(ifa.oResult), 64'd25);

    // burst with a gap, then backpressure with a beat waiting upstream
    ifa.iReady = 1'b0;
    send_a(32'd25, 1'b0);
    send_a(32'd36, 1'b0);
    tick(1);
    send_a(32'd49, 1'b0);
    send_a(32'd64, 1'b1);
    chk("burst_valid", 64'(ifa.oValid), 64'd1);
    chk("burst_result", 64'(ifa.oResult), 64'd174);
    chk("burst_count", 64'(ifa.oCount), 64'd4);
    ifa.iValid = 1'b1; ifa.iProduct = 32'd99;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bp_ready", 64'(ifa.oReady), 64'd0);
      chk("bp_result", 64'(ifa.oResult), 64'd174);
      chk("bp_count", 64'(ifa.oCount), 64'd4);
    end
    ifa.iReady = 1'b1;
    tick(1);
    ifa.iValid = 1'b0;
    chk("bp_release_valid", 64'(ifa.oValid), 64'd0);
    chk("bp_release_ready", 64'(ifa.oReady), 64'd1);
    chk("bp_release_result", 64'(ifa.oResult), 64'd174);

    // reset in the middle of a burst
    ifa.iReady = 1'b0;
    send_a(32'd7, 1'b0);
    send_a(32'd7, 1'b0);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk_reset_a("midreset");
    send_a(32'd4, 1'b1);
    chk("after_reset_result", 64'(ifa.oResult), 64'd4);
    chk("after_reset_count", 64'(ifa.oCount), 64'd1);
    chk("after_reset_valid", 64'(ifa.oValid), 64'd1);
    ifa.iReady = 1'b1;
    tick(1);
    ifa.iReady = 1'b0;

    // randomized bursts on the wide instance
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < len; i++) begin
        p = $urandom;
        q.push_back(64'(p));
        send_a(p, (i == len - 1));
        if (i < len - 1 && $urandom_range(0, 2) == 0) tick(1);
      end
      model(q, 40, er, eo);
      chk("rand_a_valid", 64'(ifa.oValid), 64'd1);
      chk("rand_a_result", 64'(ifa.oResult), er);
      chk("rand_a_count", 64'(ifa.oCount), 64'(len));
      chk("rand_a_ovf", 64'(ifa.oOverflow), 64'(eo));
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        tick(1);
        chk("rand_a_stable", 64'(ifa.oResult), er);
      end
      ifa.iReady = 1'b1;
      tick(1);
      chk("rand_a_release", 64'(ifa.oValid), 64'd0);
      ifa.iReady = 1'b0;
    end

    // overflow on the 33-bit instance
    q = {};
    for (int i = 0; i < 3; i++) begin
      q.push_back(64'hFFFF_FFFF);
      send_b(32'hFFFF_FFFF, (i == 2));
    end
    chk("ovf_flag", 64'(ifb.oOverflow), 64'd1);
    chk("ovf_result", 64'(ifb.oResult), SAT ? 64'h1_FFFF_FFFF : 64'h0_FFFF_FFFD);
    chk("ovf_count", 64'(ifb.oCount), 64'd3);
    ifb.iReady = 1'b1;
    tick(1);
    ifb.iReady = 1'b0;

    // forced close at the beat-counter limit, overflow flag cleared
    for (int i = 0; i < 3; i++) send_b(32'd10, 1'b0);
    chk("limit_valid", 64'(ifb.oValid), 64'd1);
    chk("limit_result", 64'(ifb.oResult), 64'd30);
    chk("limit_count", 64'(ifb.oCount), 64'd3);
    chk("limit_ovf_clear", 64'(ifb.oOverflow), 64'd0);
    ifb.iReady = 1'b1;
    tick(1);
    ifb.iReady = 1'b0;

    // randomized bursts on the narrow instance, biased to large products
    for (int b = 0; b < 10; b++) begin
      len = $urandom_range(1, 3);
      q = {};
      for (int i = 0; i < len; i++) begin
        p = $urandom;
        if ($urandom_range(0, 1) == 1) p = p | 32'hC000_0000;
        lst = (i == len - 1) ? ((len == 3) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        q.push_back(64'(p));
        send_b(p, lst);
      end
      model(q, 33, er, eo);
      chk("rand_b_valid", 64'(ifb.oValid), 64'd1);
      chk("rand_b_result", 64'(ifb.oResult), er);
      chk("rand_b_count", 64'(ifb.oCount), 64'(len));
      chk("rand_b_ovf", 64'(ifb.oOverflow), 64'(eo));
      ifb.iReady = 1'b1;
      tick(1);
      chk("rand_b_release", 64'(ifb.oReady), 64'd1);
      ifb.iReady = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream stage of the 16x16 LUT multiplier. Consumes its 32-bit unsigned product stream and accumulates a burst of products into a wide sum.
- Presents the finished sum to the MiniALU result path through a valid/ready handshake.
- Provides backpressure to the multiplier feed while a result is waiting to be consumed.

Parameters:
- PROD_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator/result width; must be greater than PROD_W.
- CNT_W, 8, beat-counter width; the maximum burst is 2^CNT_W-1 beats.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- iProduct  in  PROD_W  unsigned product from the multiplier
- iValid  in  1  iProduct is valid this cycle
- iLast  in  1  qualifies the final beat of a burst
- oReady  out  1  stage can accept a beat
- oResult  out  ACC_W  accumulated sum
- oCount  out  CNT_W  number of beats in oResult
- oValid  out  1  oResult/oCount/oOverflow are valid
- iReady  in  1  consumer accepts the result
- oOverflow  out  1  sum exceeded ACC_W bits during this burst

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: oResult=0, oCount=0, oValid=0, oOverflow=0, oReady=1, state=IDLE.
- Reset mid-burst or in HOLD discards the partial or pending result. The next cycle is IDLE.
- A beat is accepted on a rising edge when iValid && oReady.
- States:
  - IDLE: on accept, acc=iProduct, count=1, ovf=0. Go to HOLD if the beat ends the burst, otherwise go to ACCUM.
  - ACCUM: on accept, acc=acc+iProduct, count=count+1. Go to HOLD if the beat ends the burst. No accept means hold and stay in ACCUM.
  - HOLD: oValid=1, oReady=0. On iReady, go to IDLE: oValid=0 and oReady=1 from the next cycle. oResult, oCount and oOverflow keep their values after the handshake until the next burst's first accept.
- A beat ends the burst if iLast=1, or if it makes count reach 2^CNT_W-1. The forced close happens even when iLast=0.
- Latency: the closing beat is accepted at edge k; oValid=1 and the final sum are visible after edge k. There is no back-to-back accept in the HOLD cycle.
- iValid while oReady=0 is ignored and the beat is not captured. The upstream must hold it.
- While oValid && !iReady, oResult, oCount and oOverflow are stable.
- Arithmetic: unsigned. iProduct is zero-extended to ACC_W+1. The carry-out at bit ACC_W sets the sticky ovf, which is cleared by the first accept of the next burst.
- Without saturation, the sum wraps modulo 2^ACC_W.
- iLast without iValid has no effect.

Optional Feature:
- Macro: MULT_ACC_SAT_EN
- Defined: on carry-out, acc is clamped to all ones (2^ACC_W-1). It stays clamped for the rest of the burst, and oOverflow=1.
- Undefined: the sum wraps modulo 2^ACC_W and oOverflow=1. Port list and timing are identical in both builds.

Decomposition:
- Package mult_pkg holds:
  - PROD_W and ACC_W defaults.
  - The state enumeration IDLE/ACCUM/HOLD, 2-bit encoded.
- One natural sub-module, acc_sat_add (combinational):
  - Inputs: acc and iProduct.
  - Outputs: next sum and the carry flag.
  - It is the only place affected by MULT_ACC_SAT_EN.
- The FSM, counter and handshake stay in mult_accumulator.

Test Plan:
- Single beat: iProduct=25 (5*5), iValid=1, iLast=1, iReady=1 -> one cycle later oValid=1, oResult=25, oCount=1, oOverflow=0. The cycle after, oValid=0 and oReady=1.
- Burst: 25, 36, 49, 64 with iLast on the 4th beat, with one idle cycle (iValid=0) after beat 2 -> oResult=174, oCount=4.
- Backpressure: after the burst closes, iReady=0 for 3 cycles while iValid=1, iProduct=99 -> oReady=0, oResult stays 174, 99 is never accumulated. Then iReady=1 -> IDLE, oReady=1.
- Overflow with ACC_W=33: three beats of 32'hFFFFFFFF, iLast on the 3rd -> oOverflow=1.
  - Without MULT_ACC_SAT_EN: oResult=33'h0FFFFFFFD.
  - With MULT_ACC_SAT_EN: oResult=33'h1FFFFFFFF.
- Count limit with CNT_W=2: three beats of 10 with iLast=0 -> forced HOLD after the 3rd beat, oResult=30, oCount=3.
- Reset mid-burst: two beats of 7, then Reset=1 for 1 cycle -> all outputs at reset values. A new single beat of 4 with iLast -> oResult=4, oCount=1.
